// File: rtl/sort_result_serializer.sv
// Serializes four sorted words from a parallel load onto a valid/ready stream, i1 first.
// Optional capture-order checking is enabled by defining SORT_CHECK_EN.
module sort_result_serializer #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    output logic         in_ready,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    input  logic [N-1:0] i4,
    output logic [N-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy,
    output logic         order_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] b [4];
    logic [1:0]   idx;
    logic         accept;
    logic         last_hs;

    // A load on the last beat is accepted in the same cycle, so groups run without a bubble.
    assign last_hs  = (state == SEND) && (idx == 2'd3) && tx_ready;
    assign in_ready = (state == IDLE) || last_hs;
    assign accept   = load && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (last_hs) state_nxt = accept ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == SEND);
        tx_last  = (state == SEND) && (idx == 2'd3);
        tx_data  = (state == SEND) ? b[idx] : '0;
        busy     = tx_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int unsigned k = 0; k < 4; k++) b[k] <= '0;
        end else if (accept) begin
            idx  <= '0;
            b[0] <= i1;
            b[1] <= i2;
            b[2] <= i3;
            b[3] <= i4;
        end else if (state == SEND && tx_ready) begin
            idx <= idx + 2'd1;
        end
    end

`ifdef SORT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            order_err <= 1'b0;
        else if (accept && !((i1 <= i2) && (i2 <= i3) && (i3 <= i4)))
            order_err <= 1'b1;
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed self-checking bench for sort_result_serializer (N=7).
module tb_sort_result_serializer;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         in_ready;
    logic [N-1:0] i1 = '0, i2 = '0, i3 = '0, i4 = '0;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         tx_last;
    logic         busy;
    logic         order_err;

    int errors = 0;
    int checks = 0;

`ifdef SORT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    sort_result_serializer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .in_ready(in_ready),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input int a, input int b, input int c, input int d);
        i1 = N'(a); i2 = N'(b); i3 = N'(c); i4 = N'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b1; set_words(1, 2, 3, 4); tx_ready = 1'b1;
        step(); step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 7'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", tx_data); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", tx_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL reset_order_err got=%b exp=0", order_err); end
        load = 1'b0; tx_ready = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_single_group();
        int exp_d[4] = '{3, 9, 40, 127};
        set_words(3, 9, 40, 127); load = 1'b1; tx_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready_idle got=%b exp=1", in_ready); end
        step();
        load = 1'b0; set_words(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat%0d got=%b exp=1", k, tx_valid); end
            checks++; if (tx_data !== N'(exp_d[k])) begin errors++; $display("FAIL single_data beat%0d got=%0d exp=%0d", k, tx_data, exp_d[k]); end
            checks++; if (tx_last !== (k == 3)) begin errors++; $display("FAIL single_last beat%0d got=%b exp=%b", k, tx_last, k == 3); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got=%b exp=0", tx_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        logic rdy[7]   = '{1, 0, 0, 1, 0, 1, 1};
        int   exp_d[7] = '{3, 9, 9, 9, 40, 40, 127};
        int   seq_exp[4] = '{3, 9, 40, 127};
        int   seen[$];
        tx_ready = 1'b0;
        set_words(3, 9, 40, 127); load = 1'b1;
        step();
        for (int c = 0; c < 7; c++) begin
            tx_ready = rdy[c];
            // Junk load while idx<3 must be ignored.
            load = (c >= 1 && c <= 5);
            set_words(100, 101, 102, 103);
            #1;
            checks++; if (tx_data !== N'(exp_d[c])) begin errors++; $display("FAIL bp_data cyc%0d got=%0d exp=%0d", c, tx_data, exp_d[c]); end
            checks++; if (tx_last !== (c == 6)) begin errors++; $display("FAIL bp_last cyc%0d got=%b exp=%b", c, tx_last, c == 6); end
            checks++; if (in_ready !== (c == 6)) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b exp=%b", c, in_ready, c == 6); end
            if (tx_valid && tx_ready) seen.push_back(int'(tx_data));
            step();
        end
        load = 1'b0; tx_ready = 1'b0;
        #1;
        checks++; if (seen.size() != 4) begin errors++; $display("FAIL bp_beat_count got=%0d exp=4", seen.size()); end
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            checks++; if (seen[k] != seq_exp[k]) begin errors++; $display("FAIL bp_seq beat%0d got=%0d exp=%0d", k, seen[k], seq_exp[k]); end
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_back_to_back();
        set_words(1, 2, 3, 4); load = 1'b1; tx_ready = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin set_words(5, 6, 7, 8); load = 1'b1; end
            else load = 1'b0;
            #1;
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc%0d got=%b exp=1", c, tx_valid); end
            checks++; if (tx_data !== N'(c + 1)) begin errors++; $display("FAIL b2b_data cyc%0d got=%0d exp=%0d", c, tx_data, c + 1); end
            checks++; if (tx_last !== (c == 3 || c == 7)) begin errors++; $display("FAIL b2b_last cyc%0d got=%b exp=%b", c, tx_last, c == 3 || c == 7); end
            if (c == 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
            end
            step();
        end
        load = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_mid_reset();
        set_words(10, 20, 30, 40); load = 1'b1; tx_ready = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        checks++; if (tx_data !== 7'd30) begin errors++; $display("FAIL mr_pre_data got=%0d exp=30", tx_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 7'd0) begin errors++; $display("FAIL mr_data got=%0d exp=0", tx_data); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL mr_last got=%b exp=0", tx_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got=%b exp=1", in_ready); end
        load = 1'b1; set_words(99, 98, 97, 96);
        step();
        load = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_after_valid cyc%0d got=%b exp=0 data=%0d", c, tx_valid, tx_data); end
        end
        set_words(0, 0, 0, 0); load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 7'd0) begin errors++; $display("FAIL mr_zero beat%0d got valid=%b data=%0d exp valid=1 data=0", k, tx_valid, tx_data); end
            checks++; if (tx_last !== (k == 3)) begin errors++; $display("FAIL mr_zero_last beat%0d got=%b exp=%b", k, tx_last, k == 3); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_end_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_order_check();
        int exp_d[8] = '{5, 4, 6, 7, 1, 2, 3, 4};
        checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL oc_initial got=%b exp=0", order_err); end
        set_words(5, 4, 6, 7); load = 1'b1; tx_ready = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin set_words(1, 2, 3, 4); load = 1'b1; end
            else load = 1'b0;
            #1;
            checks++; if (order_err !== EXP_ERR) begin errors++; $display("FAIL oc_err cyc%0d got=%b exp=%b", c, order_err, EXP_ERR); end
            checks++; if (tx_data !== N'(exp_d[c])) begin errors++; $display("FAIL oc_data cyc%0d got=%0d exp=%0d", c, tx_data, exp_d[c]); end
            step();
        end
        load = 1'b0;
        step();
        checks++; if (order_err !== EXP_ERR) begin errors++; $display("FAIL oc_sticky got=%b exp=%b", order_err, EXP_ERR); end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_order_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
